tsi_serial_width_adapter: RTL and testbench

//  Narrow-link stage between the SimTsi host bridge (32-bit TSI words, ready/valid) and the

---
 rtl/tsi_pkg.sv | 17 +
 rtl/tsi_word_deserializer.sv | 71 +++++++
 rtl/tsi_serial_width_adapter.sv | 82 ++++++++
 tb/tb_tsi_serial_width_adapter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsi_pkg.sv
// rtl/tsi_pkg.sv - shared TSI width constant and beat/counter sizing helpers
package tsi_pkg;

  // Host-side TSI word width (SimTsi data width).
  localparam int TSI_W = 32;

  // Number of chip-side beats that make up one host word.
  function automatic int tsi_beats(input int ser_w, input int tsi_w = TSI_W);
    return tsi_w / ser_w;
  endfunction

  // Beat counter width; never narrower than one bit so BEATS==1 still has a counter.
  function automatic int tsi_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/tsi_word_deserializer.sv
// rtl/tsi_word_deserializer.sv - reassembles chip beats into host words (assembly + holding register)
module tsi_word_deserializer #(
  parameter int TSI_W = tsi_pkg::TSI_W,
  parameter int SER_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             beat_valid_i,
  output logic             beat_ready_o,
  input  logic [SER_W-1:0] beat_bits_i,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [TSI_W-1:0] word_bits_o
);
  import tsi_pkg::tsi_beats;
  import tsi_pkg::tsi_cnt_w;

  localparam int BEATS = tsi_beats(SER_W, TSI_W);
  localparam int CNT_W = tsi_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  logic [TSI_W-1:0] rreg_q;
  logic [TSI_W-1:0] rreg_d;
  logic [TSI_W-1:0] hreg_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic             word_valid_q;
  logic             last_beat;
  logic             beat_fire;
  logic             word_fire;

  assign last_beat = (rx_cnt_q == LAST);

  // Beats keep landing in the assembly register while a finished word waits in the
  // holding register; only the beat that would complete a new word has to wait for
  // the host. With one beat per word every beat completes a word, so this reduces
  // to !word_valid || word_ready.
  assign beat_ready_o = !reset && (!word_valid_q || word_ready_i || !last_beat);
  assign beat_fire    = beat_valid_i && beat_ready_o;
  assign word_fire    = word_valid_q && word_ready_i;

  assign word_valid_o = word_valid_q;
  assign word_bits_o  = hreg_q;

  // Merge the incoming beat into its slot of the partially assembled word.
  always_comb begin
    rreg_d = rreg_q;
    rreg_d[int'(rx_cnt_q) * SER_W +: SER_W] = beat_bits_i;
  end

  // Advance the beat counter; the completing beat moves the whole word to the holding register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rreg_q       <= '0;
      hreg_q       <= '0;
      rx_cnt_q     <= '0;
      word_valid_q <= 1'b0;
    end else begin
      if (beat_fire) begin
        if (last_beat) begin
          hreg_q   <= rreg_d;
          rx_cnt_q <= '0;
        end else begin
          rreg_q   <= rreg_d;
          rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        end
      end
      word_valid_q <= (beat_fire && last_beat) || (word_valid_q && !word_fire);
    end
  end

endmodule

// File: rtl/tsi_serial_width_adapter.sv
// rtl/tsi_serial_width_adapter.sv - host TSI word <-> chip narrow serial beat adapter
module tsi_serial_width_adapter #(
  parameter int TSI_W = tsi_pkg::TSI_W,
  parameter int SER_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  input  logic [TSI_W-1:0] host_in_bits,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic [TSI_W-1:0] host_out_bits,
  output logic             ser_out_valid,
  input  logic             ser_out_ready,
  output logic [SER_W-1:0] ser_out_bits,
  input  logic             ser_in_valid,
  output logic             ser_in_ready,
  input  logic [SER_W-1:0] ser_in_bits
);
  import tsi_pkg::tsi_beats;
  import tsi_pkg::tsi_cnt_w;

  localparam int BEATS = tsi_beats(SER_W, TSI_W);
  localparam int CNT_W = tsi_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (TSI_W % SER_W != 0) begin : g_bad_ser_w
    $error("tsi_serial_width_adapter: SER_W must divide TSI_W");
  end

  logic             ser_valid_q;
  logic [TSI_W-1:0] sreg_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic             tx_last;
  logic             host_in_fire;
  logic             ser_out_fire;

  assign tx_last       = (tx_cnt_q == LAST);
  // A new word may load while the final beat of the current one leaves, so words abut.
  assign host_in_ready = !reset && (!ser_valid_q || (ser_out_ready && tx_last));
  assign host_in_fire  = host_in_valid && host_in_ready;
  assign ser_out_fire  = ser_valid_q && ser_out_ready;

  assign ser_out_valid = ser_valid_q;
  assign ser_out_bits  = sreg_q[SER_W-1:0];

  // Serializer: load on host accept, shift out LSB beat first, drop valid after the last beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      ser_valid_q <= 1'b0;
      sreg_q      <= '0;
      tx_cnt_q    <= '0;
    end else if (host_in_fire) begin
      ser_valid_q <= 1'b1;
      sreg_q      <= host_in_bits;
      tx_cnt_q    <= '0;
    end else if (ser_out_fire) begin
      if (tx_last) begin
        ser_valid_q <= 1'b0;
      end else begin
        sreg_q   <= sreg_q >> SER_W;
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end
    end
  end

  tsi_word_deserializer #(
    .TSI_W (TSI_W),
    .SER_W (SER_W)
  ) u_deser (
    .clock        (clock),
    .reset        (reset),
    .beat_valid_i (ser_in_valid),
    .beat_ready_o (ser_in_ready),
    .beat_bits_i  (ser_in_bits),
    .word_valid_o (host_out_valid),
    .word_ready_i (host_out_ready),
    .word_bits_o  (host_out_bits)
  );

endmodule

// File: tb/tb_tsi_serial_width_adapter.sv
// tb/tb_tsi_serial_width_adapter.sv - self-checking bench for the TSI serial width adapter
module tb_tsi_serial_width_adapter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // DUT A: SER_W = 4
  logic        a_host_in_valid, a_host_in_ready, a_host_out_valid, a_host_out_ready;
  logic [31:0] a_host_in_bits, a_host_out_bits;
  logic        a_ser_out_valid, a_ser_out_ready, a_ser_in_valid, a_ser_in_ready;
  logic [3:0]  a_ser_out_bits, a_ser_in_bits;

  // DUT B: SER_W = 32
  logic        b_host_in_valid, b_host_in_ready, b_host_out_valid, b_host_out_ready;
  logic [31:0] b_host_in_bits, b_host_out_bits;
  logic        b_ser_out_valid, b_ser_out_ready, b_ser_in_valid, b_ser_in_ready;
  logic [31:0] b_ser_out_bits, b_ser_in_bits;

  tsi_serial_width_adapter #(.TSI_W(32), .SER_W(4)) dut_a (
    .clock(clock), .reset(reset),
    .host_in_valid(a_host_in_valid), .host_in_ready(a_host_in_ready), .host_in_bits(a_host_in_bits),
    .host_out_valid(a_host_out_valid), .host_out_ready(a_host_out_ready), .host_out_bits(a_host_out_bits),
    .ser_out_valid(a_ser_out_valid), .ser_out_ready(a_ser_out_ready), .ser_out_bits(a_ser_out_bits),
    .ser_in_valid(a_ser_in_valid), .ser_in_ready(a_ser_in_ready), .ser_in_bits(a_ser_in_bits)
  );

  tsi_serial_width_adapter #(.TSI_W(32), .SER_W(32)) dut_b (
    .clock(clock), .reset(reset),
    .host_in_valid(b_host_in_valid), .host_in_ready(b_host_in_ready), .host_in_bits(b_host_in_bits),
    .host_out_valid(b_host_out_valid), .host_out_ready(b_host_out_ready), .host_out_bits(b_host_out_bits),
    .ser_out_valid(b_ser_out_valid), .ser_out_ready(b_ser_out_ready), .ser_out_bits(b_ser_out_bits),
    .ser_in_valid(b_ser_in_valid), .ser_in_ready(b_ser_in_ready), .ser_in_bits(b_ser_in_bits)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0]  a_ser_q[$];
  logic [31:0] a_host_q[$];
  logic [31:0] b_ser_q[$];
  logic [31:0] b_host_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops the oldest expected value.
  always @(negedge clock) begin
    if (a_ser_out_valid && a_ser_out_ready) begin
      check("a_ser_q_nonempty", a_ser_q.size() != 0, 1);
      if (a_ser_q.size() != 0) check("a_ser_beat", a_ser_out_bits, a_ser_q.pop_front());
    end
    if (a_host_out_valid && a_host_out_ready) begin
      check("a_host_q_nonempty", a_host_q.size() != 0, 1);
      if (a_host_q.size() != 0) check("a_host_word", a_host_out_bits, a_host_q.pop_front());
    end
    if (b_ser_out_valid && b_ser_out_ready) begin
      check("b_ser_q_nonempty", b_ser_q.size() != 0, 1);
      if (b_ser_q.size() != 0) check("b_ser_word", b_ser_out_bits, b_ser_q.pop_front());
    end
    if (b_host_out_valid && b_host_out_ready) begin
      check("b_host_q_nonempty", b_host_q.size() != 0, 1);
      if (b_host_q.size() != 0) check("b_host_word", b_host_out_bits, b_host_q.pop_front());
    end
  end

  // Offer a word to DUT A; valid is left high so a caller can chain words back to back.
  task automatic tx_word_a(input logic [31:0] w);
    int n;
    n = 0;
    a_host_in_valid = 1'b1;
    a_host_in_bits  = w;
    @(negedge clock);
    while (!a_host_in_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("tx_accept_wait", a_host_in_ready, 1);
    for (int i = 0; i < 8; i++) a_ser_q.push_back(w[4*i +: 4]);
    @(posedge clock);
    #1;
  endtask

  // Feed cnt beats of w into DUT A starting at beat index first, LSB nibble first.
  task automatic rx_beats_a(input logic [31:0] w, input int first, input int cnt);
    int n;
    if (first == 0) a_host_q.push_back(w);
    for (int i = first; i < first + cnt; i++) begin
      a_ser_in_valid = 1'b1;
      a_ser_in_bits  = w[4*i +: 4];
      n = 0;
      @(negedge clock);
      while (!a_ser_in_ready && n < 100) begin
        n++;
        @(negedge clock);
      end
      check("rx_accept_wait", a_ser_in_ready, 1);
      @(posedge clock);
      #1;
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  mask;   // ser_out_ready pattern, bit k used on cycle k mod 8
    logic [3:0]  first;
    logic [3:0]  last;
  } tx_vec_t;

  tx_vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires, k, t0, ok;
    logic prev_stall;
    logic [3:0] prev_bits, last_bits;

    vecs[0] = '{32'h12345678, 8'b01010101, 4'h8, 4'h1};
    vecs[1] = '{32'hCAFEF00D, 8'b00110011, 4'hD, 4'hC};
    vecs[2] = '{32'hF000000F, 8'b10000001, 4'hF, 4'hF};
    vecs[3] = '{32'hA5A5A5A5, 8'b11111110, 4'h5, 4'hA};

    reset = 1'b1;
    a_host_in_valid = 0; a_host_in_bits = '0; a_host_out_ready = 1;
    a_ser_out_ready = 1; a_ser_in_valid = 0; a_ser_in_bits = '0;
    b_host_in_valid = 0; b_host_in_bits = '0; b_host_out_ready = 1;
    b_ser_out_ready = 1; b_ser_in_valid = 0; b_ser_in_bits = '0;
    repeat (3) @(posedge clock);
    #1;

    // reset state
    @(negedge clock);
    check("rst_a_host_in_ready", a_host_in_ready, 0);
    check("rst_a_ser_in_ready", a_ser_in_ready, 0);
    check("rst_a_ser_out_valid", a_ser_out_valid, 0);
    check("rst_a_host_out_valid", a_host_out_valid, 0);
    check("rst_a_ser_out_bits", a_ser_out_bits, 0);
    check("rst_a_host_out_bits", a_host_out_bits, 0);
    check("rst_b_host_in_ready", b_host_in_ready, 0);
    check("rst_b_ser_in_ready", b_ser_in_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_a_host_in_ready", a_host_in_ready, 1);
    check("idle_a_ser_in_ready", a_ser_in_ready, 1);
    @(posedge clock);
    #1;

    // 1: single word, beats 8..1 on consecutive cycles, host_in_ready only on last beat
    tx_word_a(32'h12345678);
    a_host_in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("t1_ser_out_valid", a_ser_out_valid, 1);
      check("t1_host_in_ready", a_host_in_ready, (i == 7));
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("t1_idle_after", a_ser_out_valid, 0);
    @(posedge clock);
    #1;

    // 2: table of words under ser_out_ready stall patterns
    foreach (vecs[v]) begin
      tx_word_a(vecs[v].word);
      a_host_in_valid = 0;
      fires = 0; k = 0; prev_stall = 0; prev_bits = '0; last_bits = '0;
      while (fires < 8 && k < 64) begin
        a_ser_out_ready = vecs[v].mask[k % 8];
        @(negedge clock);
        if (k == 0) check("t2_first_beat", a_ser_out_bits, vecs[v].first);
        if (prev_stall) check("t2_stall_stable", a_ser_out_bits, prev_bits);
        if (a_ser_out_valid && a_ser_out_ready) begin
          fires++;
          last_bits = a_ser_out_bits;
        end
        prev_stall = a_ser_out_valid && !a_ser_out_ready;
        prev_bits  = a_ser_out_bits;
        @(posedge clock);
        #1;
        k++;
      end
      a_ser_out_ready = 1;
      check("t2_fire_count", fires, 8);
      check("t2_last_beat", last_bits, vecs[v].last);
      @(negedge clock);
      check("t2_idle_after", a_ser_out_valid, 0);
      @(posedge clock);
      #1;
    end

    // 3: deserialize with host stalled; next word assembles, its final beat waits
    a_host_out_ready = 0;
    rx_beats_a(32'h89ABCDEF, 0, 8);
    a_ser_in_valid = 0;
    @(negedge clock);
    check("t3_word_valid", a_host_out_valid, 1);
    check("t3_word_bits", a_host_out_bits, 32'h89ABCDEF);
    @(posedge clock);
    #1;
    rx_beats_a(32'h01234567, 0, 7);
    a_ser_in_valid = 1;
    a_ser_in_bits  = 4'h0;
    @(negedge clock);
    check("t3_stall_ready", a_ser_in_ready, 0);
    check("t3_held_bits", a_host_out_bits, 32'h89ABCDEF);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t3_stall_ready2", a_ser_in_ready, 0);
    @(posedge clock);
    #1;
    a_host_out_ready = 1;
    @(negedge clock);
    check("t3_release_ready", a_ser_in_ready, 1);
    @(posedge clock);
    #1;
    a_ser_in_valid = 0;
    @(negedge clock);
    check("t3_second_valid", a_host_out_valid, 1);
    check("t3_second_bits", a_host_out_bits, 32'h01234567);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t3_drained", a_host_out_valid, 0);
    @(posedge clock);
    #1;

    // 4: back-to-back words in both directions, one beat per cycle
    fork
      begin
        tx_word_a(32'h0F1E2D3C);
        tx_word_a(32'h4B5A6978);
        a_host_in_valid = 0;
      end
      begin
        t0 = cyc;
        rx_beats_a(32'h11223344, 0, 8);
        rx_beats_a(32'h55667788, 0, 8);
        a_ser_in_valid = 0;
        check("t4_rx_cycles", cyc - t0, 16);
      end
      begin
        ok = 0; k = 0;
        @(negedge clock);
        while (!a_ser_out_valid && k < 20) begin
          k++;
          @(negedge clock);
        end
        for (int i = 0; i < 16; i++) begin
          if (i > 0) @(negedge clock);
          if (a_ser_out_valid && a_ser_out_ready) ok++;
        end
        check("t4_tx_sustained", ok, 16);
        @(negedge clock);
        check("t4_tx_idle_after", a_ser_out_valid, 0);
      end
    join
    repeat (3) @(posedge clock);
    #1;

    // 5: reset in mid-word in both directions, then a clean word
    tx_word_a(32'hDEADBEEF);
    a_host_in_valid = 0;
    rx_beats_a(32'h76543210, 0, 3);
    a_ser_in_valid = 0;
    reset = 1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t5_ser_out_valid", a_ser_out_valid, 0);
    check("t5_ser_out_bits", a_ser_out_bits, 0);
    check("t5_host_out_valid", a_host_out_valid, 0);
    check("t5_host_out_bits", a_host_out_bits, 0);
    check("t5_host_in_ready", a_host_in_ready, 0);
    check("t5_ser_in_ready", a_ser_in_ready, 0);
    @(posedge clock);
    #1;
    reset = 0;
    a_ser_q.delete();
    a_host_q.delete();
    fork
      begin
        tx_word_a(32'hCAFEF00D);
        a_host_in_valid = 0;
      end
      begin
        rx_beats_a(32'hCAFEF00D, 0, 8);
        a_ser_in_valid = 0;
      end
    join
    repeat (12) @(posedge clock);
    #1;
    check("t5_ser_q_drained", a_ser_q.size(), 0);
    check("t5_host_q_drained", a_host_q.size(), 0);

    // 6: SER_W = 32, single-entry pipes
    b_host_in_valid = 1;
    b_host_in_bits  = 32'h13579BDF;
    @(negedge clock);
    check("t6_host_in_ready", b_host_in_ready, 1);
    b_ser_q.push_back(32'h13579BDF);
    @(posedge clock);
    #1;
    b_host_in_valid = 0;
    @(negedge clock);
    check("t6_ser_out_valid", b_ser_out_valid, 1);
    check("t6_ser_out_bits", b_ser_out_bits, 32'h13579BDF);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t6_ser_out_idle", b_ser_out_valid, 0);
    @(posedge clock);
    #1;
    b_ser_in_valid = 1;
    b_ser_in_bits  = 32'h2468ACE0;
    b_host_q.push_back(32'h2468ACE0);
    @(negedge clock);
    check("t6_ser_in_ready", b_ser_in_ready, 1);
    @(posedge clock);
    #1;
    b_ser_in_bits = 32'h0BADF00D;
    b_host_q.push_back(32'h0BADF00D);
    @(negedge clock);
    check("t6_word1_valid", b_host_out_valid, 1);
    check("t6_word1_bits", b_host_out_bits, 32'h2468ACE0);
    check("t6_overlap_ready", b_ser_in_ready, 1);
    @(posedge clock);
    #1;
    b_ser_in_valid = 0;
    @(negedge clock);
    check("t6_word2_valid", b_host_out_valid, 1);
    check("t6_word2_bits", b_host_out_bits, 32'h0BADF00D);
    @(posedge clock);
    #1;
    b_host_out_ready = 0;
    b_ser_in_valid = 1;
    b_ser_in_bits  = 32'h11111111;
    b_host_q.push_back(32'h11111111);
    @(posedge clock);
    #1;
    b_ser_in_bits = 32'h22222222;
    b_host_q.push_back(32'h22222222);
    @(negedge clock);
    check("t6_stall_ready", b_ser_in_ready, 0);
    @(posedge clock);
    #1;
    b_host_out_ready = 1;
    @(negedge clock);
    check("t6_release_ready", b_ser_in_ready, 1);
    @(posedge clock);
    #1;
    b_ser_in_valid = 0;
    repeat (4) @(posedge clock);
    #1;

    check("end_a_ser_q", a_ser_q.size(), 0);
    check("end_a_host_q", a_host_q.size(), 0);
    check("end_b_ser_q", b_ser_q.size(), 0);
    check("end_b_host_q", b_host_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
